// File: rtl/output_readout_controller.sv
// Streams the finished output frame from the 64-bit output RAM to the host
// as two 32-bit beats per word (low half first) over a valid/ready handshake.
module output_readout_controller #(
  parameter int FRAME_WORDS = 38400,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              output_ready,
  input  logic              rd_start,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [63:0]       ram_data,
  output logic [31:0]       stream_data,
  output logic              stream_valid,
  input  logic              stream_ready,
  output logic              stream_last,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SEND_LO = 3'd3,
    SEND_HI = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t      state_r;
  logic [31:0] hold_hi_r;
  logic        beat_accept_s;
  logic        at_last_s;

  // The word address doubles as the word counter, so the last word is known
  // without a separate count.
  assign beat_accept_s = stream_valid && stream_ready;
  assign at_last_s     = (ram_address == LAST_ADDR);

  // Readout sequencer: owns the RAM address and every host-facing output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      hold_hi_r    <= 32'd0;
      ram_address  <= {ADDR_W{1'b0}};
      stream_data  <= 32'd0;
      stream_valid <= 1'b0;
      stream_last  <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rd_start && output_ready) begin
            ram_address <= {ADDR_W{1'b0}};
            busy        <= 1'b1;
            state_r     <= READ;
          end
        end
        READ: begin
          state_r <= LATCH;
        end
        LATCH: begin
          // Only the high half needs holding; the low half goes out now.
          hold_hi_r    <= ram_data[63:32];
          stream_data  <= ram_data[31:0];
          stream_valid <= 1'b1;
          stream_last  <= 1'b0;
          state_r      <= SEND_LO;
        end
        SEND_LO: begin
          if (beat_accept_s) begin
            stream_data <= hold_hi_r;
            stream_last <= at_last_s;
            state_r     <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (beat_accept_s) begin
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
            if (at_last_s) begin
              frame_done <= 1'b1;
              state_r    <= DONE;
            end else begin
              ram_address <= ram_address + ADDR_ONE;
              state_r     <= READ;
            end
          end
        end
        DONE: begin
          busy        <= 1'b0;
          ram_address <= {ADDR_W{1'b0}};
          state_r     <= IDLE;
        end
        default: begin
          state_r      <= IDLE;
          ram_address  <= {ADDR_W{1'b0}};
          stream_valid <= 1'b0;
          stream_last  <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_readout_controller.sv
// Scoreboard bench: stimulus queues expected beats, negedge monitors pop and
// compare them on each accepted beat and check stall stability.
module tb_output_readout_controller;

  localparam int BW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, output_ready;
  logic        a_rd_start, a_ready, a_valid, a_last, a_busy, a_done;
  logic [15:0] a_addr;
  logic [63:0] a_ram_q;
  logic [31:0] a_data;
  logic        b_rd_start, b_ready, b_valid, b_last, b_busy, b_done;
  logic [15:0] b_addr;
  logic [63:0] b_ram_q;
  logic [31:0] b_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int a_last_cyc = -1;
  logic [32:0] a_q[$];
  logic [32:0] b_q[$];

  output_readout_controller #(.FRAME_WORDS(1), .ADDR_W(16)) dut_a (
    .clk(clk), .reset(reset), .output_ready(output_ready), .rd_start(a_rd_start),
    .ram_address(a_addr), .ram_data(a_ram_q), .stream_data(a_data),
    .stream_valid(a_valid), .stream_ready(a_ready), .stream_last(a_last),
    .busy(a_busy), .frame_done(a_done));

  output_readout_controller #(.FRAME_WORDS(BW), .ADDR_W(16)) dut_b (
    .clk(clk), .reset(reset), .output_ready(output_ready), .rd_start(b_rd_start),
    .ram_address(b_addr), .ram_data(b_ram_q), .stream_data(b_data),
    .stream_valid(b_valid), .stream_ready(b_ready), .stream_last(b_last),
    .busy(b_busy), .frame_done(b_done));

  // Word n is {n, ~n} as two 32-bit halves.
  function automatic logic [63:0] word_of(input logic [15:0] n);
    return {16'h0000, n, 16'hFFFF, ~n};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) a_ram_q <= (a_addr == 16'd0) ? 64'h1122334455667788 : 64'h0;
  always @(posedge clk) b_ram_q <= word_of(b_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event, expected one within the cycle budget", name);
  endtask

  // Monitor for the single-word instance.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      if (a_done) begin
        a_done_cnt++;
        check("a_done_after_last", 64'(cyc), 64'(a_last_cyc + 1));
      end
      if (a_valid && a_ready) begin
        if (a_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_extra_beat: got beat %0h, expected none", a_data);
        end else begin
          e = a_q.pop_front();
          check("a_beat_data", a_data, e[31:0]);
          check("a_beat_last", a_last, e[32]);
          if (a_last) a_last_cyc = cyc;
        end
      end
    end
  end

  // Monitor for the multi-word instance, including stall stability.
  logic        b_prev_stall = 1'b0;
  logic [31:0] b_prev_data;
  logic        b_prev_last;
  logic [15:0] b_prev_addr;
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset) begin
      b_prev_stall = 1'b0;
    end else begin
      if (b_done) b_done_cnt++;
      if (b_prev_stall) begin
        check("b_stall_data", b_data, b_prev_data);
        check("b_stall_last", b_last, b_prev_last);
        check("b_stall_addr", b_addr, b_prev_addr);
      end
      if (b_valid && b_ready) begin
        if (b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_beat: got beat %0h, expected none", b_data);
        end else begin
          e = b_q.pop_front();
          check("b_beat_data", b_data, e[31:0]);
          check("b_beat_last", b_last, e[32]);
        end
      end
      b_prev_stall = b_valid && !b_ready;
      b_prev_data  = b_data;
      b_prev_last  = b_last;
      b_prev_addr  = b_addr;
    end
  end

  task automatic push_frame();
    for (int w = 0; w < BW; w++) begin
      logic [63:0] wd;
      wd = word_of(16'(w));
      b_q.push_back({1'b0, wd[31:0]});
      b_q.push_back({(w == BW - 1) ? 1'b1 : 1'b0, wd[63:32]});
    end
  endtask

  // Runs one full frame on dut_b; called #1 after a clock edge.
  task automatic b_frame(input bit bp, input bit restart_mid);
    int n, first_v, d0;
    bit pulsed;
    push_frame();
    d0 = b_done_cnt;
    n = 0;
    first_v = -1;
    pulsed = 1'b0;
    b_ready = 1'b1;
    b_rd_start = 1'b1;
    @(posedge clk); #1;
    b_rd_start = 1'b0;
    check("b_start_busy", b_busy, 1);
    check("b_start_addr", b_addr, 0);
    while (!b_done && n < 2000) begin
      if (bp) b_ready = (n % 4 == 3);
      if (restart_mid && !pulsed && b_addr == 16'd2) begin
        b_rd_start = 1'b1;
        pulsed = 1'b1;
      end else begin
        b_rd_start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (first_v < 0 && b_valid) first_v = n;
    end
    b_ready = 1'b1;
    b_rd_start = 1'b0;
    if (!b_done) fail("b_frame_timeout");
    else if (!bp) begin
      check("b_done_cycle", 64'(n), 64'(4 * BW));
      check("b_first_valid", 64'(first_v), 64'd2);
    end
    @(posedge clk); #1;
    check("b_end_busy", b_busy, 0);
    check("b_end_done", b_done, 0);
    check("b_end_addr", b_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    check("b_done_count", 64'(b_done_cnt - d0), 64'd1);
    check("b_queue_empty", 64'(b_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, d0;
    reset = 1'b1;
    output_ready = 1'b0;
    a_rd_start = 1'b0;
    b_rd_start = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", b_addr, 0);
    check("rst_data", b_data, 0);
    check("rst_valid", b_valid, 0);
    check("rst_last", b_last, 0);
    check("rst_busy", b_busy, 0);
    check("rst_done", b_done, 0);
    reset = 1'b0;

    // rd_start without output_ready is ignored.
    b_rd_start = 1'b1;
    @(posedge clk); #1;
    b_rd_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("idle_busy", b_busy, 0);
      check("idle_valid", b_valid, 0);
      check("idle_done", b_done, 0);
      check("idle_addr", b_addr, 0);
      @(posedge clk); #1;
    end

    // Single-word frame.
    output_ready = 1'b1;
    a_q.push_back({1'b0, 32'h55667788});
    a_q.push_back({1'b1, 32'h11223344});
    a_rd_start = 1'b1;
    @(posedge clk); #1;
    a_rd_start = 1'b0;
    n = 0;
    while (!a_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!a_done) fail("a_timeout");
    else check("a_done_cycle", 64'(n), 64'd4);
    repeat (3) @(posedge clk);
    #1;
    check("a_busy_end", a_busy, 0);
    check("a_done_count", 64'(a_done_cnt), 64'd1);
    check("a_queue_empty", 64'(a_q.size()), 64'd0);

    // Full frame with ready high, then backpressure with a mid-run restart.
    b_frame(1'b0, 1'b0);
    b_frame(1'b1, 1'b1);

    // Reset during SEND_HI of word 10 aborts without frame_done.
    push_frame();
    b_rd_start = 1'b1;
    @(posedge clk); #1;
    b_rd_start = 1'b0;
    n = 0;
    while (!(b_valid && b_addr == 16'd10 && b_data == 32'd10) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) fail("b_reach_word10");
    d0 = b_done_cnt;
    b_ready = 1'b0;
    reset = 1'b1;
    output_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_addr", b_addr, 0);
    check("abort_valid", b_valid, 0);
    check("abort_busy", b_busy, 0);
    check("abort_data", b_data, 0);
    reset = 1'b0;
    b_ready = 1'b1;
    b_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(b_done_cnt - d0), 64'd0);
    check("abort_idle_busy", b_busy, 0);
    output_ready = 1'b1;
    b_frame(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
